// File: rtl/reg_share_arbiter.sv
// ============================================================================
// Module   : reg_share_arbiter
// Purpose  : Round-robin arbiter sharing one W-bit q/qn register among N
//            requesters. Define ARB_LOCK_EN to add per-requester burst lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_share_arbiter #(
    parameter int             N        = 4,
    parameter int             IW       = 2,
    parameter int             W        = 8,
    parameter logic [W-1:0]   RST_VAL  = '0,
    parameter int             LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    wdata,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]      lock,
`endif
    output logic [N-1:0]      gnt,
    output logic              busy,
    output logic [IW-1:0]     owner,
    output logic [W-1:0]      q,
    output logic [W-1:0]      qn,
    output logic [7:0]        wr_cnt
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [N-1:0]    r_gnt,      w_gnt_nxt;
    logic [IW-1:0]   r_owner,    w_owner_nxt;
    logic [IW-1:0]   r_ptr,      w_ptr_nxt;
    logic [W-1:0]    r_q,        w_q_nxt;
    logic [7:0]      r_cnt,      w_cnt_nxt;
    logic [LCW-1:0]  r_lock_cnt, w_lock_cnt_nxt;

    logic [W-1:0]    w_slice [N];
    logic            w_found;
    logic [IW-1:0]   w_win;
    int              w_idx;
    logic [IW-1:0]   w_cand;
    logic            w_lock_req;
    logic            w_stay;

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign w_slice[gi] = wdata[gi*W +: W];
    end

`ifdef ARB_LOCK_EN
    assign w_lock_req = lock[r_owner];
`else
    assign w_lock_req = 1'b0;
`endif

    // A locked owner keeps the slot until it has written LOCK_MAX times in a row.
    assign w_stay = req[r_owner] && w_lock_req && ((int'(r_lock_cnt) + 1) < LOCK_MAX);

    // Rotating search starting just after the most recent winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx  = (int'(r_ptr) + k) % N;
            w_cand = w_idx[IW-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_owner_nxt    = r_owner;
        w_ptr_nxt      = r_ptr;
        w_q_nxt        = r_q;
        w_cnt_nxt      = r_cnt;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (w_found) begin
                    w_gnt_nxt[w_win] = 1'b1;
                    w_owner_nxt      = w_win;
                    w_ptr_nxt        = w_win;
                    w_lock_cnt_nxt   = '0;
                    w_state_nxt      = S_GRANT;
                end
            end
            S_GRANT: begin
                if (req[r_owner]) begin
                    w_q_nxt   = w_slice[r_owner];
                    w_cnt_nxt = r_cnt + 8'd1;
                end
                if (w_stay) begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end else begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_ptr      <= IW'(N - 1);
            r_q        <= RST_VAL;
            r_cnt      <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_q        <= w_q_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign busy   = (r_state != S_IDLE);
    assign owner  = r_owner;
    assign q      = r_q;
    assign qn     = ~r_q;
    assign wr_cnt = r_cnt;

endmodule

`default_nettype wire
